sum_loader: RTL and testbench

Control stage directly upstream of the `Sum` accumulation kernel. It accepts a word stream and writes it sequentially into the kernel's input SRAM (array `a`). It then drives the kernel's `ap_start`/`n` handshake, waits for `ap_done`, and captures `ap_return` as a registered result. It replaces bench-driven SRAM preloading and start sequencing with synthesizable control.

---
 rtl/sum_loader.sv | 178 +++++++++++++++++
 tb/tb_sum_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_loader.sv
// sum_loader: control stage in front of the Sum accumulation kernel.
//
// Accepts a job request (cfg_start/cfg_n), streams cfg_n words into the
// kernel's input SRAM, starts the kernel, waits for ap_done and captures
// ap_return as a registered result.
//
// Ports
//   ap_clk, ap_rst           clock, asynchronous active-high reset
//   cfg_start, cfg_n         job request and word count (sampled in IDLE)
//   in_data/in_valid/in_ready  input word stream
//   mem_address0/d0/ce0/we0  SRAM write port (meaningful while load_sel=1)
//   load_sel                 1 = this block owns the SRAM port
//   k_start, k_n             kernel ap_start and n
//   k_done, k_return         kernel ap_done and ap_return
//   result, result_valid     captured kernel result, one-cycle update pulse
//   busy                     high whenever the FSM is not IDLE
//   err                      one-cycle pulse on rejected job or RUN timeout
//   dbg_state                current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
//
// Stream handshake: a word transfers on every rising edge where
// in_valid && in_ready are both high. in_ready depends only on the state
// (high throughout LOAD), never on in_valid; the producer may hold in_valid
// low for any number of cycles without penalty.
module sum_loader #(
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mem_address0,
  output logic [31:0] mem_d0,
  output logic        mem_ce0,
  output logic        mem_we0,
  output logic        load_sel,
  output logic        k_start,
  output logic [31:0] k_n,
  input  logic        k_done,
  input  logic [31:0] k_return,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  // Last values driven on the SRAM address/data lines, held outside LOAD.
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    result_d     = result_q;
    err_d        = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    in_ready     = 1'b0;
    load_sel     = 1'b0;
    mem_ce0      = 1'b0;
    mem_we0      = 1'b0;
    mem_address0 = addr_q;
    mem_d0       = data_q;
    k_start      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          n_d   = cfg_n;
          cnt_d = '0;
          if (cfg_n == 32'd0) begin
            // Empty job: skip the kernel entirely, report a zero sum.
            result_d = '0;
            state_d  = S_DONE;
          end else if (cfg_n > DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        load_sel     = 1'b1;
        in_ready     = 1'b1;
        mem_address0 = cnt_q;
        mem_d0       = in_data;
        // Write strobes follow in_valid so the SRAM only captures on a
        // handshake edge.
        mem_ce0      = in_valid;
        mem_we0      = in_valid;
        addr_d       = cnt_q;
        data_d       = in_data;
        if (in_valid) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == n_q - 32'd1) begin
            timer_d = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        k_start = 1'b1;
        if (k_done) begin
          result_d = k_return;
          state_d  = S_DONE;
        end else if (timer_q == TIMEOUT_W - 32'd1) begin
          // This is the TIMEOUT-th RUN cycle with no ap_done: abort.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign k_n          = n_q;
  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sum_loader.sv
module tb_sum_loader;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 20;

  // Clock / reset
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic        cfg_start = 1'b0;
  logic [31:0] cfg_n     = '0;
  logic [31:0] in_data   = '0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] mem_address0;
  logic [31:0] mem_d0;
  logic        mem_ce0;
  logic        mem_we0;
  logic        load_sel;
  logic        k_start;
  logic [31:0] k_n;
  logic        k_done_w;
  logic [31:0] k_ret_m;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  sum_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .cfg_start    (cfg_start),
    .cfg_n        (cfg_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_address0 (mem_address0),
    .mem_d0       (mem_d0),
    .mem_ce0      (mem_ce0),
    .mem_we0      (mem_we0),
    .load_sel     (load_sel),
    .k_start      (k_start),
    .k_n          (k_n),
    .k_done       (k_done_w),
    .k_return     (k_ret_m),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // SRAM model: captures on the write edge, logs write addresses.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] wr_addr_log[$];
  always @(posedge ap_clk) begin
    if (mem_ce0 && mem_we0) begin
      mem[mem_address0[3:0]] <= mem_d0;
      wr_addr_log.push_back(mem_address0);
    end
  end

  // Kernel model: after k_start has been high for 3 cycles, pulse done
  // with the sum of the first k_n SRAM words.
  logic kernel_en = 1'b1;
  logic spur_done = 1'b0;
  logic k_done_m;
  int   kcnt;
  assign k_done_w = k_done_m | spur_done;

  function automatic logic [31:0] mem_sum(input logic [31:0] n);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) if (32'(i) < n) s = s + mem[i];
    return s;
  endfunction

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      k_done_m <= 1'b0;
      k_ret_m  <= '0;
      kcnt     <= 0;
    end else begin
      k_done_m <= 1'b0;
      if (k_start && kernel_en && !k_done_m) begin
        if (kcnt == 2) begin
          k_done_m <= 1'b1;
          k_ret_m  <= mem_sum(k_n);
          kcnt     <= 0;
        end else begin
          kcnt <= kcnt + 1;
        end
      end else begin
        kcnt <= 0;
      end
    end
  end

  // Event monitor, sampled mid-cycle (away from both clock edges).
  int rv_cnt = 0, err_cnt = 0, ks_cnt = 0, busy_cnt = 0;
  always @(posedge ap_clk) begin
    #3;
    if (result_valid) rv_cnt++;
    if (err) err_cnt++;
    if (k_start) ks_cnt++;
    if (busy) busy_cnt++;
  end

  // Driver tasks
  task automatic start_job(input logic [31:0] n);
    @(negedge ap_clk);
    cfg_start = 1'b1;
    cfg_n     = n;
    @(negedge ap_clk);
    cfg_start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [31:0] base, input bit throttle);
    for (int i = 0; i < n; i++) begin
      if (throttle) begin
        in_valid = 1'b0;
        @(negedge ap_clk);
        tests_run++;
        if (mem_we0 !== 1'b0) begin
          tests_failed++;
          $display("FAIL gap_no_write: mem_we0=%b required 0", mem_we0);
        end
      end
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      @(negedge ap_clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input string name, input int n, input logic [31:0] base,
                         input bit throttle, input logic [31:0] exp_sum);
    logic [31:0] exp_q[$];
    int c;
    wr_addr_log.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    start_job(32'(n));
    rv_cnt = 0;
    tests_run++;
    if (in_ready !== 1'b1 || load_sel !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_load_entry: ready=%b sel=%b busy=%b required 1 1 1", name, in_ready, load_sel, busy);
    end
    stream(n, base, throttle);
    tests_run++;
    if (k_start !== 1'b1 || load_sel !== 1'b0 || k_n !== 32'(n)) begin
      tests_failed++;
      $display("FAIL %s_handover: k_start=%b load_sel=%b k_n=%0d required 1 0 %0d", name, k_start, load_sel, k_n, n);
    end
    c = 0;
    while (!result_valid && c < 100) begin
      @(negedge ap_clk);
      c++;
    end
    tests_run++;
    if (result_valid !== 1'b1 || result !== exp_sum) begin
      tests_failed++;
      $display("FAIL %s_result: valid=%b result=%0d required 1 %0d", name, result_valid, result, exp_sum);
    end
    @(negedge ap_clk);
    tests_run++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || rv_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s_after: valid=%b busy=%b pulses=%0d required 0 0 1", name, result_valid, busy, rv_cnt);
    end
    tests_run++;
    if (wr_addr_log.size() !== n) begin
      tests_failed++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wr_addr_log.size(), n);
    end
    for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      tests_run++;
      if (wr_addr_log[i] !== 32'(i) || mem[i] !== e) begin
        tests_failed++;
        $display("FAIL %s_sram[%0d]: addr=%0d data=%0d required %0d %0d", name, i, wr_addr_log[i], mem[i], i, e);
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset;
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    tests_run++;
    if ({in_ready, mem_ce0, mem_we0, load_sel, k_start, result_valid, busy, err} !== 8'b0 ||
        mem_address0 !== 32'd0 || mem_d0 !== 32'd0 || k_n !== 32'd0 || result !== 32'd0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_values: ctl=%b addr=%0d d=%0d k_n=%0d result=%0d state=%0d required all 0",
               {in_ready, mem_ce0, mem_we0, load_sel, k_start, result_valid, busy, err},
               mem_address0, mem_d0, k_n, result, dbg_state);
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic test_nominal;
    run_job("nominal", 10, 32'd1, 1'b0, 32'd55);
  endtask

  task automatic test_throttled;
    run_job("throttled", 4, 32'd7, 1'b1, 32'd34);
  endtask

  task automatic test_zero_job;
    ks_cnt = 0;
    rv_cnt = 0;
    wr_addr_log.delete();
    start_job(32'd0);
    tests_run++;
    if (result_valid !== 1'b1 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL zero_result: valid=%b result=%0d required 1 0", result_valid, result);
    end
    @(negedge ap_clk);
    tests_run++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || ks_cnt !== 0 || rv_cnt !== 1 || wr_addr_log.size() !== 0) begin
      tests_failed++;
      $display("FAIL zero_after: valid=%b busy=%b kstart_cycles=%0d pulses=%0d writes=%0d required 0 0 0 1 0",
               result_valid, busy, ks_cnt, rv_cnt, wr_addr_log.size());
    end
  endtask

  task automatic test_oversize;
    err_cnt  = 0;
    busy_cnt = 0;
    start_job(32'(DEPTH + 1));
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL oversize_err: err=%b busy=%b required 1 0", err, busy);
    end
    repeat (3) @(negedge ap_clk);
    tests_run++;
    if (err_cnt !== 1 || busy_cnt !== 0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL oversize_after: err_pulses=%0d busy_cycles=%0d err=%b required 1 0 0", err_cnt, busy_cnt, err);
    end
  endtask

  task automatic test_max_depth;
    // 16 words 100..115 -> 1600 + 120
    run_job("max_depth", DEPTH, 32'd100, 1'b0, 32'd1720);
  endtask

  task automatic test_timeout;
    int cyc;
    kernel_en = 1'b0;
    err_cnt   = 0;
    start_job(32'd2);
    stream(2, 32'd40, 1'b0);
    cyc = 0;
    while (k_start && cyc < 100) begin
      cyc++;
      @(negedge ap_clk);
    end
    tests_run++;
    if (cyc !== TIMEOUT || err !== 1'b1 || k_start !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_abort: run_cycles=%0d err=%b k_start=%b busy=%b required %0d 1 0 0",
               cyc, err, k_start, busy, TIMEOUT);
    end
    tests_run++;
    if (result !== 32'd1720) begin
      tests_failed++;
      $display("FAIL timeout_result_kept: result=%0d required 1720", result);
    end
    @(negedge ap_clk);
    tests_run++;
    if (err !== 1'b0 || err_cnt !== 1) begin
      tests_failed++;
      $display("FAIL timeout_err_pulse: err=%b pulses=%0d required 0 1", err, err_cnt);
    end
    kernel_en = 1'b1;
    run_job("after_timeout", 2, 32'd5, 1'b0, 32'd11);
  endtask

  task automatic test_reset_mid_load;
    start_job(32'd10);
    stream(3, 32'd1, 1'b0);
    ap_rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, mem_ce0, mem_we0, load_sel, k_start, result_valid, busy, err} !== 8'b0 ||
        mem_address0 !== 32'd0 || mem_d0 !== 32'd0 || k_n !== 32'd0 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset_values: ctl=%b addr=%0d d=%0d k_n=%0d result=%0d required all 0",
               {in_ready, mem_ce0, mem_we0, load_sel, k_start, result_valid, busy, err},
               mem_address0, mem_d0, k_n, result);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    ks_cnt = 0;
    repeat (5) @(negedge ap_clk);
    tests_run++;
    if (ks_cnt !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_no_start: kstart_cycles=%0d busy=%b required 0 0", ks_cnt, busy);
    end
    run_job("after_reset", 3, 32'd1, 1'b0, 32'd6);
  endtask

  task automatic test_spurious;
    int c;
    start_job(32'd3);
    // cfg_start during LOAD alongside the first word
    in_valid  = 1'b1;
    in_data   = 32'd4;
    cfg_start = 1'b1;
    cfg_n     = 32'd5;
    @(negedge ap_clk);
    cfg_start = 1'b0;
    in_data   = 32'd5;
    @(negedge ap_clk);
    in_data   = 32'd6;
    @(negedge ap_clk);
    in_valid  = 1'b0;
    // cfg_start during RUN
    cfg_start = 1'b1;
    cfg_n     = 32'd7;
    @(negedge ap_clk);
    cfg_start = 1'b0;
    c = 0;
    while (!result_valid && c < 100) begin
      @(negedge ap_clk);
      c++;
    end
    tests_run++;
    if (result_valid !== 1'b1 || result !== 32'd15 || k_n !== 32'd3) begin
      tests_failed++;
      $display("FAIL spurious_cfg: valid=%b result=%0d k_n=%0d required 1 15 3", result_valid, result, k_n);
    end
    @(negedge ap_clk);
    rv_cnt    = 0;
    busy_cnt  = 0;
    spur_done = 1'b1;
    @(negedge ap_clk);
    spur_done = 1'b0;
    repeat (3) @(negedge ap_clk);
    tests_run++;
    if (rv_cnt !== 0 || busy_cnt !== 0 || result !== 32'd15) begin
      tests_failed++;
      $display("FAIL spurious_done: pulses=%0d busy_cycles=%0d result=%0d required 0 0 15", rv_cnt, busy_cnt, result);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_throttled();
    test_zero_job();
    test_oversize();
    test_max_depth();
    test_timeout();
    test_reset_mid_load();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule
